// File: rtl/nanov_spi_mem_arbiter.sv
// Two-client arbiter in front of one bit-serial SPI memory (0x03 READ / 0x02 WRITE).
// The winning request is latched and then shifted out as command, address and data, one bit per clk.
module nanov_spi_mem_arbiter #(
    parameter int ADDR_BITS = 24,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [1:0]           size0,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [31:0]          wdata0,
    output logic                 done0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [1:0]           size1,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [31:0]          wdata1,
    output logic                 done1,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 grant,
    output logic                 spi_select,
    output logic                 spi_clk_enable,
    output logic                 spi_out,
    input  logic                 spi_data_in,
    output logic [2:0]           dbg_state
);

    localparam int SR_W  = 7 + ADDR_BITS + 32;
    localparam int CNT_W = $clog2((ADDR_BITS > 32) ? ADDR_BITS : 32);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_END  = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [SR_W-1:0]    tx_sr;
    logic               we_q;
    logic [1:0]         size_q;
    logic [31:0]        rx_buf;
    logic               rr_prio;

    logic               arb_valid;
    logic               arb_sel;
    logic               sel_we;
    logic [1:0]         sel_size;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [31:0]        sel_wdata;
    logic [31:0]        tx_data;
    logic [7:0]         cmd;
    logic [CNT_W-1:0]   data_last;
    logic               phase_last;
    logic [31:0]        rx_next;

    // rr_prio names the client that wins a tie; it points away from the last grant.
    always_comb begin
        arb_valid = req0 | req1;
        arb_sel   = 1'b0;
        if (req0 && req1) begin
            arb_sel = RR_ENABLE ? rr_prio : 1'b0;
        end else if (req1) begin
            arb_sel = 1'b1;
        end
        sel_we    = arb_sel ? we1    : we0;
        sel_size  = arb_sel ? size1  : size0;
        sel_addr  = arb_sel ? addr1  : addr0;
        sel_wdata = arb_sel ? wdata1 : wdata0;
        cmd       = sel_we ? 8'h02 : 8'h03;
        // Byte 0 goes on the wire first, so it sits at the top of the shift register.
        tx_data   = sel_we ? {sel_wdata[7:0], sel_wdata[15:8], sel_wdata[23:16], sel_wdata[31:24]}
                           : 32'h0;
    end

    always_comb begin
        case (size_q)
            2'd0:    data_last = CNT_W'(7);
            2'd1:    data_last = CNT_W'(15);
            default: data_last = CNT_W'(31);
        endcase
        case (state)
            S_CMD:   phase_last = (cnt == CNT_W'(7));
            S_ADDR:  phase_last = (cnt == CNT_W'(ADDR_BITS - 1));
            S_DATA:  phase_last = (cnt == data_last);
            default: phase_last = 1'b0;
        endcase
        // DATA cycle n fills byte n/8, bit 7 - n%8.
        rx_next = rx_buf;
        rx_next[{cnt[4:3], ~cnt[2:0]}] = spi_data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            tx_sr          <= '0;
            we_q           <= 1'b0;
            size_q         <= 2'd0;
            rx_buf         <= 32'h0;
            rr_prio        <= 1'b0;
            grant          <= 1'b0;
            rdata          <= 32'h0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            spi_select     <= 1'b1;
            spi_clk_enable <= 1'b0;
            spi_out        <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        state          <= S_CMD;
                        cnt            <= '0;
                        grant          <= arb_sel;
                        rr_prio        <= ~arb_sel;
                        we_q           <= sel_we;
                        size_q         <= sel_size;
                        tx_sr          <= {cmd[6:0], sel_addr, tx_data};
                        rx_buf         <= 32'h0;
                        spi_out        <= cmd[7];
                        spi_select     <= 1'b0;
                        spi_clk_enable <= 1'b1;
                    end
                end
                S_CMD, S_ADDR, S_DATA: begin
                    cnt <= phase_last ? '0 : cnt + 1'b1;
                    if (state == S_DATA) begin
                        rx_buf <= rx_next;
                    end
                    if (state == S_DATA && phase_last) begin
                        state          <= S_END;
                        spi_select     <= 1'b1;
                        spi_clk_enable <= 1'b0;
                        spi_out        <= 1'b0;
                        done0          <= ~grant;
                        done1          <= grant;
                        if (!we_q) begin
                            rdata <= rx_next;
                        end
                    end else begin
                        spi_out <= tx_sr[SR_W-1];
                        tx_sr   <= tx_sr << 1;
                        if (phase_last) begin
                            state <= (state == S_CMD) ? S_ADDR : S_DATA;
                        end
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule
